uart_tx: RTL and testbench

Byte-wide UART transmitter that serialises 8-bit data onto a single `tx` line as start, 8 data bits (LSB first), optional parity, and 1 or 2 stop bits. Bit timing comes from an external `baud_tick` strobe shared with the receive path, so one baud generator serves both directions. A one-entry holding register behind a valid/ready handshake lets the host queue the next byte during a frame, which allows gapless back-to-back frames.

---
 rtl/uart_tx.sv | 137 +++++++++++++
 tb/tb_uart_tx.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// Byte-wide UART transmitter: start, 8 data bits LSB first, optional parity, 1-2 stop bits.
// Bit timing comes from a shared baud_tick strobe; a one-entry holding register allows gapless frames.
module uart_tx #(
  parameter bit parity_en  = 1'b1,
  parameter bit parity_odd = 1'b0,
  parameter int stop_bits  = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       baud_tick,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  typedef enum logic [2:0] {IDLE, SYNC, START, DATA, PARITY, STOP} state_t;

  state_t     state;
  logic [7:0] hold;
  logic       hold_valid;
  logic [7:0] shift;
  logic       par_bit;
  logic [2:0] bit_cnt;
  logic       stop_cnt;
  logic       accept;
  logic       last_stop;
  logic       load;

  assign tx_ready  = !hold_valid;
  assign tx_busy   = (state != IDLE);
  assign accept    = tx_valid && tx_ready;
  assign last_stop = (stop_cnt == 1'(stop_bits - 1));
  // Holding register drains into the shifter either from IDLE or straight out of the last stop bit.
  assign load      = hold_valid &&
                     ((state == IDLE) || (state == STOP && baud_tick && last_stop));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      hold       <= 8'h00;
      hold_valid <= 1'b0;
      shift      <= 8'h00;
      par_bit    <= 1'b0;
      bit_cnt    <= 3'd0;
      stop_cnt   <= 1'b0;
      tx         <= 1'b1;
      tx_done    <= 1'b0;
    end else begin
      tx_done <= 1'b0;

      if (accept) begin
        hold       <= tx_data;
        hold_valid <= 1'b1;
      end else if (load) begin
        hold_valid <= 1'b0;
      end

      if (load) begin
        shift   <= hold;
        par_bit <= parity_odd ? ~^hold : ^hold;
      end

      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (hold_valid) state <= SYNC;
        end
        SYNC: begin
          tx <= 1'b1;
          if (baud_tick) begin
            tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (baud_tick) begin
            tx      <= shift[0];
            bit_cnt <= 3'd0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (baud_tick) begin
            if (bit_cnt == 3'd7) begin
              if (parity_en) begin
                tx    <= par_bit;
                state <= PARITY;
              end else begin
                tx       <= 1'b1;
                stop_cnt <= 1'b0;
                state    <= STOP;
              end
            end else begin
              shift   <= {1'b0, shift[7:1]};
              tx      <= shift[1];
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
        PARITY: begin
          if (baud_tick) begin
            tx       <= 1'b1;
            stop_cnt <= 1'b0;
            state    <= STOP;
          end
        end
        STOP: begin
          if (baud_tick) begin
            if (last_stop) begin
              tx_done  <= 1'b1;
              stop_cnt <= 1'b0;
              // A queued byte starts its start bit on this very edge: no SYNC, no gap.
              if (hold_valid) begin
                tx    <= 1'b0;
                state <= START;
              end else begin
                tx    <= 1'b1;
                state <= IDLE;
              end
            end else begin
              tx       <= 1'b1;
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: three instances cover even/1-stop, odd/2-stop and no-parity framing.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       baud_tick = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [2:0] vld = 3'b000;
  logic [2:0] rdy_w, tx_w, busy_w, done_w;

  int n_checks = 0;
  int n_err = 0;
  int done_cnt [3] = '{0, 0, 0};
  logic tick_en = 1'b0;
  int tick_div = 0;

  always #5 clk = ~clk;

  uart_tx #(.parity_en(1'b1), .parity_odd(1'b0), .stop_bits(1)) u_even (
    .clk(clk), .reset_n(reset_n), .baud_tick(baud_tick), .tx_data(tx_data),
    .tx_valid(vld[0]), .tx_ready(rdy_w[0]), .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]));

  uart_tx #(.parity_en(1'b1), .parity_odd(1'b1), .stop_bits(2)) u_odd (
    .clk(clk), .reset_n(reset_n), .baud_tick(baud_tick), .tx_data(tx_data),
    .tx_valid(vld[1]), .tx_ready(rdy_w[1]), .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]));

  uart_tx #(.parity_en(1'b0), .parity_odd(1'b0), .stop_bits(1)) u_nopar (
    .clk(clk), .reset_n(reset_n), .baud_tick(baud_tick), .tx_data(tx_data),
    .tx_valid(vld[2]), .tx_ready(rdy_w[2]), .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]));

  // One-clk baud strobe every 16 clk, changed away from both clock edges.
  always @(posedge clk) begin
    #2;
    if (tick_en) begin
      if (tick_div == 15) begin
        tick_div  = 0;
        baud_tick = 1'b1;
      end else begin
        tick_div  = tick_div + 1;
        baud_tick = 1'b0;
      end
    end else begin
      tick_div  = 0;
      baud_tick = 1'b0;
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) if (done_w[k]) done_cnt[k] = done_cnt[k] + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns #1 after the clock edge that sampled baud_tick high.
  task automatic wait_tick();
    int guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!baud_tick && guard < 64);
    if (!baud_tick) chk("tick_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Aligns just after a tick, hands a byte over and checks accept and SYNC entry.
  task automatic send(input int sel, input logic [7:0] d);
    wait_tick();
    @(negedge clk);
    vld[sel] = 1'b1;
    tx_data  = d;
    @(posedge clk); #1;
    chk("accept_ready_low", 32'(rdy_w[sel]), 32'd0);
    @(negedge clk);
    vld[sel] = 1'b0;
    @(posedge clk); #1;
    chk("sync_busy", 32'(busy_w[sel]), 32'd1);
    chk("sync_tx_high", 32'(tx_w[sel]), 32'd1);
    chk("sync_ready_back", 32'(rdy_w[sel]), 32'd1);
  endtask

  // Checks tx after each tick edge against a '0'/'1' string, then the done edge.
  task automatic run_frame(input int sel, input string s, input logic end_tx, input logic end_busy);
    for (int i = 0; i < s.len(); i++) begin
      wait_tick();
      chk($sformatf("tx_bit%0d_u%0d", i, sel), 32'(tx_w[sel]), (s[i] == "1") ? 32'd1 : 32'd0);
      if (i == 0) begin
        repeat (8) @(posedge clk);
        #1;
        chk("start_mid_period", 32'(tx_w[sel]), 32'd0);
      end
    end
    wait_tick();
    chk("done_pulse", 32'(done_w[sel]), 32'd1);
    chk("end_tx", 32'(tx_w[sel]), 32'(end_tx));
    chk("end_busy", 32'(busy_w[sel]), 32'(end_busy));
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done_w[sel]), 32'd0);
  endtask

  initial begin
    // Reset values
    #12;
    for (int k = 0; k < 3; k++) begin
      chk("rst_tx", 32'(tx_w[k]), 32'd1);
      chk("rst_ready", 32'(rdy_w[k]), 32'd1);
      chk("rst_busy", 32'(busy_w[k]), 32'd0);
      chk("rst_done", 32'(done_w[k]), 32'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;

    // Idle ticks do nothing
    tick_en = 1'b1;
    repeat (3) wait_tick();
    chk("idle_tick_tx", 32'(tx_w[0]), 32'd1);
    chk("idle_tick_busy", 32'(busy_w[0]), 32'd0);

    // Even parity 0xA5, accepted mid-period so SYNC waits for the next tick
    send(0, 8'hA5);
    run_frame(0, "01010010101", 1'b1, 1'b0);

    // Odd parity, two stop bits, 0x07
    send(1, 8'h07);
    run_frame(1, "011100000011", 1'b1, 1'b0);

    // No parity, 0xFF
    send(2, 8'hFF);
    run_frame(2, "0111111111", 1'b1, 1'b0);

    // Back-to-back 0x55 then 0xAA with tx_valid held high
    wait_tick();
    @(negedge clk);
    vld[0]  = 1'b1;
    tx_data = 8'h55;
    @(posedge clk); #1;
    chk("b2b_first_accept", 32'(rdy_w[0]), 32'd0);
    @(negedge clk);
    tx_data = 8'hAA;
    @(posedge clk); #1;
    chk("b2b_ready_after_load", 32'(rdy_w[0]), 32'd1);
    @(posedge clk); #1;
    chk("b2b_second_accept", 32'(rdy_w[0]), 32'd0);
    @(negedge clk);
    vld[0] = 1'b0;
    run_frame(0, "01010101001", 1'b0, 1'b1);
    chk("b2b_ready_after_reload", 32'(rdy_w[0]), 32'd1);
    run_frame(0, "0101010101", 1'b1, 1'b0);

    // Reset in DATA bit 3 with a byte queued
    send(0, 8'h00);
    repeat (5) wait_tick();
    chk("pre_reset_bit3", 32'(tx_w[0]), 32'd0);
    @(negedge clk);
    vld[0]  = 1'b1;
    tx_data = 8'h81;
    @(posedge clk); #1;
    chk("queued_ready_low", 32'(rdy_w[0]), 32'd0);
    @(negedge clk);
    vld[0] = 1'b0;
    #3;
    reset_n = 1'b0;
    #1;
    chk("midrst_tx", 32'(tx_w[0]), 32'd1);
    chk("midrst_busy", 32'(busy_w[0]), 32'd0);
    chk("midrst_ready", 32'(rdy_w[0]), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) wait_tick();
    chk("post_rst_tx", 32'(tx_w[0]), 32'd1);
    chk("post_rst_busy", 32'(busy_w[0]), 32'd0);

    chk("done_count_even", 32'(done_cnt[0]), 32'd3);
    chk("done_count_odd", 32'(done_cnt[1]), 32'd1);
    chk("done_count_nopar", 32'(done_cnt[2]), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
